data_mem_responder: RTL and testbench

Memory-side responder for the data port of the RV32I pipeline's memory stage. It accepts one load/store request at a time over a valid/ready handshake, services it from an internal word array after a fixed, parameterised latency, and returns read data or a store acknowledgement over a second valid/ready handshake. Byte, half and word accesses are supported, with sign- or zero-extension on loads and an error flag for misaligned or out-of-range accesses. It is the target the core's load/store path connects to when the memory stage is made stall-capable.

---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the memory stage (master) and the data memory responder (slave).
// Both channels use valid/ready: a transfer happens on a rising edge where valid && ready; the sender holds its payload while valid && !ready.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder backed by a word array, with fixed access latency,
// sub-word lane handling, load extension and misalign/range error reporting.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  data_mem_responder_if.slave     bus,
  output logic [1:0]              dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        enter_resp;

  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        acc_we;
  logic [31:0] acc_addr;
  logic [1:0]  acc_size;
  logic        acc_uns;
  logic [31:0] acc_wdata;
  logic [29:0] widx;
  logic [31:0] cur_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;
  logic        acc_err;
  logic [31:0] acc_rdata;
  logic [3:0]  wmask;
  logic [31:0] wword;

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          cnt_next   = 4'(LATENCY - 1);
          state_next = (LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      // Counter reaches zero on the edge LATENCY-1 after accept, so RESP is entered at accept+LATENCY.
      S_WAIT: begin
        if (cnt == 4'd0) state_next = S_RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign enter_resp = (state_next == S_RESP) && (state != S_RESP);

  // With LATENCY=1 the access happens on the accept edge itself, so it must see the live request.
  always_comb begin
    if (state == S_IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_size  = bus.req_size;
      acc_uns   = bus.req_unsigned;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_size  = size_q;
      acc_uns   = uns_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    widx     = acc_addr[31:2];
    cur_word = mem[widx[AW-1:0]];
    unique case (acc_addr[1:0])
      2'd0:    byte_sel = cur_word[7:0];
      2'd1:    byte_sel = cur_word[15:8];
      2'd2:    byte_sel = cur_word[23:16];
      default: byte_sel = cur_word[31:24];
    endcase
    half_sel = acc_addr[1] ? cur_word[31:16] : cur_word[15:0];

    acc_err = (widx >= 30'(DEPTH_WORDS));
    ld_data = cur_word;
    wmask   = 4'b1111;
    wword   = acc_wdata;
    unique case (acc_size)
      2'b00: begin
        ld_data = acc_uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        wmask   = 4'b0001 << acc_addr[1:0];
        wword   = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        ld_data = acc_uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        wmask   = acc_addr[1] ? 4'b1100 : 4'b0011;
        wword   = {2{acc_wdata[15:0]}};
        if (acc_addr[0]) acc_err = 1'b1;
      end
      2'b10: begin
        if (acc_addr[1:0] != 2'd0) acc_err = 1'b1;
      end
      default: acc_err = 1'b1;
    endcase
    acc_rdata = (acc_err || acc_we) ? 32'd0 : ld_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == S_IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        wdata_q <= bus.req_wdata;
      end
      if (enter_resp) begin
        rdata_q <= acc_rdata;
        err_q   <= acc_err;
      end
    end
  end

  // Array is not reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[widx[AW-1:0]][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance for data-path tests and a
// LATENCY=4 instance for the reset-during-WAIT case, checked through one response scoreboard.
module tb_data_mem_responder;

  logic clk;
  logic rst_a, rst_b;
  logic sel;

  logic        req_valid, req_we, req_unsigned, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [1:0]  dbg_a, dbg_b;

  logic [32:0] exp_q[$];
  int checks, errors;

  data_mem_responder_if bus_a();
  data_mem_responder_if bus_b();

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a), .dbg_state(dbg_a));
  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b), .dbg_state(dbg_b));

  assign bus_a.req_valid    = req_valid && !sel;
  assign bus_a.req_we       = req_we;
  assign bus_a.req_addr     = req_addr;
  assign bus_a.req_size     = req_size;
  assign bus_a.req_unsigned = req_unsigned;
  assign bus_a.req_wdata    = req_wdata;
  assign bus_a.resp_ready   = resp_ready;
  assign bus_b.req_valid    = req_valid && sel;
  assign bus_b.req_we       = req_we;
  assign bus_b.req_addr     = req_addr;
  assign bus_b.req_size     = req_size;
  assign bus_b.req_unsigned = req_unsigned;
  assign bus_b.req_wdata    = req_wdata;
  assign bus_b.resp_ready   = resp_ready;

  wire        cur_ready = sel ? bus_b.req_ready  : bus_a.req_ready;
  wire        cur_valid = sel ? bus_b.resp_valid : bus_a.resp_valid;
  wire [31:0] cur_rdata = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
  wire        cur_err   = sel ? bus_b.resp_err   : bus_a.resp_err;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor: pops one expectation per response handshake
  always @(negedge clk) begin
    if (cur_valid && resp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got rdata 0x%08h err %0b with no request pending", cur_rdata, cur_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({cur_err, cur_rdata} !== e) begin
          errors++;
          $display("FAIL resp: got err %0b rdata 0x%08h expected err %0b rdata 0x%08h",
                   cur_err, cur_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  // issue one request, check accept-to-valid latency; returns once resp_valid is seen
  task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int lat;
    lat = sel ? 4 : 2;
    exp_q.push_back({exp_err, exp_rdata});
    @(negedge clk);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!cur_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5; req_size = 2'b11;
    n = 0;
    while (!cur_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, lat);
  endtask

  task automatic finish_resp();
    int n;
    n = 0;
    while (cur_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("resp_drain", 32'(n < 50), 32'd1);
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    send(we, addr, size, uns, wdata, exp_rdata, exp_err);
    finish_resp();
  endtask

  initial begin
    checks = 0; errors = 0;
    sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_size = 2'b10;
    req_unsigned = 1'b0; req_wdata = 32'd0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus_a.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus_a.resp_valid), 32'd0);
    check("rst_resp_rdata", bus_a.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus_a.resp_err), 32'd0);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;

    // word round trip
    xact(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0);
    xact(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0);

    // byte / half extension
    xact(1'b1, 32'h20, 2'b10, 1'b0, 32'h0000_8080, 32'd0, 1'b0);
    xact(1'b0, 32'h20, 2'b00, 1'b0, 32'd0, 32'hFFFF_FF80, 1'b0);
    xact(1'b0, 32'h20, 2'b00, 1'b1, 32'd0, 32'h0000_0080, 1'b0);
    xact(1'b0, 32'h20, 2'b01, 1'b0, 32'd0, 32'hFFFF_8080, 1'b0);
    xact(1'b0, 32'h20, 2'b01, 1'b1, 32'd0, 32'h0000_8080, 1'b0);
    xact(1'b0, 32'h21, 2'b00, 1'b0, 32'd0, 32'hFFFF_FF80, 1'b0);
    xact(1'b0, 32'h22, 2'b01, 1'b0, 32'd0, 32'h0000_0000, 1'b0);

    // sub-word store lanes
    xact(1'b1, 32'h30, 2'b10, 1'b0, 32'h1122_3344, 32'd0, 1'b0);
    xact(1'b1, 32'h32, 2'b00, 1'b0, 32'hFFFF_FFAA, 32'd0, 1'b0);
    xact(1'b0, 32'h30, 2'b10, 1'b0, 32'd0, 32'h11AA_3344, 1'b0);
    xact(1'b1, 32'h30, 2'b01, 1'b0, 32'h1234_BEEF, 32'd0, 1'b0);
    xact(1'b0, 32'h30, 2'b10, 1'b0, 32'd0, 32'h11AA_BEEF, 1'b0);
    xact(1'b0, 32'h33, 2'b00, 1'b1, 32'd0, 32'h0000_0011, 1'b0);

    // errors leave word 0 intact
    xact(1'b1, 32'h0, 2'b10, 1'b0, 32'h0102_0304, 32'd0, 1'b0);
    xact(1'b1, 32'h1, 2'b01, 1'b0, 32'h0000_FFFF, 32'd0, 1'b1);
    xact(1'b0, 32'h0, 2'b10, 1'b0, 32'd0, 32'h0102_0304, 1'b0);
    xact(1'b1, 32'h0, 2'b11, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1);
    xact(1'b0, 32'h0, 2'b11, 1'b0, 32'd0, 32'd0, 1'b1);
    xact(1'b0, 32'h0, 2'b10, 1'b0, 32'd0, 32'h0102_0304, 1'b0);
    xact(1'b0, 32'h1000, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1);
    xact(1'b1, 32'h1000, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1);
    xact(1'b0, 32'h2, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1);
    xact(1'b0, 32'h0, 2'b10, 1'b0, 32'd0, 32'h0102_0304, 1'b0);

    // backpressure
    resp_ready = 1'b0;
    send(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(bus_a.resp_valid), 32'd1);
      check("bp_rdata", bus_a.resp_rdata, 32'hDEAD_BEEF);
      check("bp_err", 32'(bus_a.resp_err), 32'd0);
      check("bp_req_ready", 32'(bus_a.req_ready), 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(bus_a.resp_valid), 32'd0);
    check("bp_release_ready", 32'(bus_a.req_ready), 32'd1);

    // reset during WAIT on the LATENCY=4 instance
    sel = 1'b1;
    xact(1'b1, 32'h40, 2'b10, 1'b0, 32'h1234_5678, 32'd0, 1'b0);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h40; req_size = 2'b10; req_unsigned = 1'b0;
    req_wdata = 32'h0000_0055; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort_accepted", 32'(bus_b.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    check("abort_resp_valid", 32'(bus_b.resp_valid), 32'd0);
    check("abort_req_ready", 32'(bus_b.req_ready), 32'd1);
    @(negedge clk);
    rst_b = 1'b1;
    xact(1'b0, 32'h40, 2'b10, 1'b0, 32'd0, 32'h1234_5678, 1'b0);
    xact(1'b0, 32'h40, 2'b00, 1'b1, 32'd0, 32'h0000_0078, 1'b0);

    repeat (4) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
